itag_ctrl: RTL and testbench

ITAG_CTRL -- requirements
Module: itag_ctrl

---
 rtl/itag_pkg.sv | 17 +
 rtl/itag_flush_counter.sv | 26 ++
 rtl/itag_ctrl.sv | 118 +++++++++++
 tb/tb_itag_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/itag_pkg.sv
// itag_pkg: shared state encoding and tag-entry layout for the instruction tag controller
package itag_pkg;

    localparam int TAG_W_DEF = 20;

    typedef enum logic [1:0] {
        INIT_FLUSH,
        RUN,
        FLUSH
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/itag_flush_counter.sv
// itag_flush_counter: line-pair index for invalidation, saturating at its final value
module itag_flush_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;

    // advance while enabled, hold at the final pair, clear once the flush completes
    always_comb cnt_d = clr_i ? '0 : (en_i && !last_o) ? cnt_q + 1'b1 : cnt_q;

    // counter register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

endmodule

// File: rtl/itag_ctrl.sv
// itag_ctrl: tag lookup/fill/flush sequencing in front of an external dual-port tag bank
module itag_ctrl
    import itag_pkg::*;
#(
    parameter int LINES = 512,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(LINES)-1:0] req_line,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     resp_valid,
    output logic                     resp_hit,
    input  logic                     fill_valid,
    output logic                     fill_ready,
    input  logic [$clog2(LINES)-1:0] fill_line,
    input  logic [TAG_W-1:0]         fill_tag,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic                     flush_done,
    output logic                     tb_en_a,
    output logic                     tb_wen_a,
    output logic [$clog2(LINES)-1:0] tb_addr_a,
    output logic [TAG_W:0]           tb_data_in_a,
    input  logic [TAG_W:0]           tb_data_out_a,
    output logic                     tb_en_b,
    output logic                     tb_wen_b,
    output logic [$clog2(LINES)-1:0] tb_addr_b,
    output logic [TAG_W:0]           tb_data_in_b
);

    localparam int AW = $clog2(LINES);
    localparam int CW = AW - 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           busy;
    logic           acc_req, acc_fill, byp_d;
    logic           resp_valid_q, byp_q, flush_done_q;
    logic [TAG_W-1:0] tag_q, byp_tag_q;
    entry_t         rd;

    assign busy       = state_q != RUN;
    assign acc_req    = req_valid && !busy;
    assign acc_fill   = fill_valid && !busy;
    assign byp_d      = acc_req && acc_fill && (req_line == fill_line);
    assign rd         = tb_data_out_a;
    assign req_ready  = !busy;
    assign fill_ready = !busy;
    assign flush_busy = busy;
    assign flush_done = flush_done_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_valid_q && (byp_q ? byp_tag_q == tag_q : rd.valid && rd.tag == tag_q);

    itag_flush_counter #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (busy),
        .clr_i (busy && last),
        .cnt_o (cnt),
        .last_o(last)
    );

    // next state and tag-bank port drive: lookups/fills in RUN, pairwise invalidation otherwise
    always_comb begin
        state_d      = state_q;
        tb_en_a      = acc_req;
        tb_wen_a     = 1'b0;
        tb_addr_a    = req_line;
        tb_data_in_a = '0;
        tb_en_b      = acc_fill;
        tb_wen_b     = acc_fill;
        tb_addr_b    = fill_line;
        tb_data_in_b = {1'b1, fill_tag};
        if (busy) begin
            tb_en_a      = 1'b1;
            tb_wen_a     = 1'b1;
            tb_addr_a    = {cnt, 1'b0};
            tb_en_b      = 1'b1;
            tb_wen_b     = 1'b1;
            tb_addr_b    = {cnt, 1'b1};
            tb_data_in_b = '0;
            state_d      = last ? RUN : state_q;
        end else begin
            state_d      = flush_req ? FLUSH : RUN;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= INIT_FLUSH;
        else     state_q <= state_d;

    // one-deep lookup pipeline with same-line fill bypass, plus the flush completion pulse
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            resp_valid_q <= 1'b0;
            byp_q        <= 1'b0;
            tag_q        <= '0;
            byp_tag_q    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            resp_valid_q <= acc_req;
            byp_q        <= byp_d;
            tag_q        <= acc_req ? req_tag : tag_q;
            byp_tag_q    <= byp_d ? fill_tag : byp_tag_q;
            flush_done_q <= state_q == FLUSH && last;
        end

endmodule

// File: tb/tb_itag_ctrl.sv
// tb_itag_ctrl: directed checks of lookup, fill, bypass, flush and reset behaviour
module tb_itag_ctrl;

    localparam int LINES = 512;
    localparam int TAG_W = 20;
    localparam int AW    = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, resp_valid, resp_hit;
    logic [AW-1:0]    req_line, fill_line;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             fill_valid, fill_ready;
    logic             flush_req, flush_busy, flush_done;
    logic             tb_en_a, tb_wen_a, tb_en_b, tb_wen_b;
    logic [AW-1:0]    tb_addr_a, tb_addr_b;
    logic [TAG_W:0]   tb_data_in_a, tb_data_out_a, tb_data_in_b;

    int cmp   = 0;
    int fails = 0;

    logic [TAG_W:0] mem [LINES] = '{default: '1};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_en_a) begin
            if (tb_wen_a) mem[tb_addr_a] <= tb_data_in_a;
            else          tb_data_out_a  <= mem[tb_addr_a];
        end
        if (tb_en_b && tb_wen_b) mem[tb_addr_b] <= tb_data_in_b;
    end

    itag_ctrl #(.LINES(LINES), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_line     (req_line),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_line    (fill_line),
        .fill_tag     (fill_tag),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .tb_en_a      (tb_en_a),
        .tb_wen_a     (tb_wen_a),
        .tb_addr_a    (tb_addr_a),
        .tb_data_in_a (tb_data_in_a),
        .tb_data_out_a(tb_data_out_a),
        .tb_en_b      (tb_en_b),
        .tb_wen_b     (tb_wen_b),
        .tb_addr_b    (tb_addr_b),
        .tb_data_in_b (tb_data_in_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_valid(input string tag);
        int v = 0;
        for (int i = 0; i < LINES; i++) if (mem[i][TAG_W] !== 1'b0) v++;
        check(tag, v, 0);
    endtask

    // called at the negedge on which reset was just released
    task automatic init_flush_check(input string tag);
        int bad = 0;
        for (int i = 0; i < LINES / 2; i++) begin
            #1;
            if (i == 0) begin
                check({tag, "_first_addr_a"}, {tb_en_a, tb_wen_a, tb_addr_a}, {2'b11, 9'd0});
                check({tag, "_first_addr_b"}, {tb_en_b, tb_wen_b, tb_addr_b}, {2'b11, 9'd1});
            end
            if (flush_busy !== 1'b1 || req_ready !== 1'b0 || fill_ready !== 1'b0 || flush_done !== 1'b0) bad++;
            @(negedge clk);
        end
        #1;
        check({tag, "_busy_cycles_bad"}, bad, 0);
        check({tag, "_ready_after"}, {req_ready, fill_ready, flush_busy}, 3'b110);
        check({tag, "_no_done"}, flush_done, 0);
        count_valid({tag, "_valid_left"});
    endtask

    initial begin
        int n;
        logic [3:0] exp_hit;
        rst = 1'b1; req_valid = 0; req_line = '0; req_tag = '0;
        fill_valid = 0; fill_line = '0; fill_tag = '0; flush_req = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", flush_busy, 1);
        check("rst_ready", {req_ready, fill_ready}, 0);
        check("rst_resp", {resp_valid, resp_hit, flush_done}, 0);
        @(negedge clk);
        rst = 1'b0;
        init_flush_check("init");

        check("idle_en", {tb_en_a, tb_en_b}, 0);

        @(negedge clk);
        fill_valid = 1; fill_line = 9'd5; fill_tag = 20'hABCDE;
        #1;
        check("fill_port_b", {tb_en_b, tb_wen_b, tb_addr_b}, {2'b11, 9'd5});
        check("fill_data_b", tb_data_in_b, 21'h1ABCDE);
        @(negedge clk);
        fill_valid = 0; req_valid = 1; req_line = 9'd5; req_tag = 20'hABCDE;
        #1;
        check("lookup_port_a", {tb_en_a, tb_wen_a, tb_addr_a}, {2'b10, 9'd5});
        check("lookup_no_resp_yet", resp_valid, 0);
        @(negedge clk);
        req_tag = 20'hABCDF;
        #1;
        check("hit_match", {resp_valid, resp_hit}, 2'b11);
        @(negedge clk);
        req_valid = 0;
        #1;
        check("hit_mismatch", {resp_valid, resp_hit}, 2'b10);
        @(negedge clk);
        #1;
        check("resp_idle", resp_valid, 0);

        fill_valid = 1; fill_line = 9'd9; fill_tag = 20'h12345;
        req_valid = 1; req_line = 9'd9; req_tag = 20'h12345;
        @(negedge clk);
        fill_line = 9'd11; fill_tag = 20'h11111; req_line = 9'd11; req_tag = 20'h22222;
        #1;
        check("bypass_hit", {resp_valid, resp_hit}, 2'b11);
        @(negedge clk);
        fill_valid = 0; req_valid = 0;
        #1;
        check("bypass_tag_miss", {resp_valid, resp_hit}, 2'b10);

        @(negedge clk);
        fill_valid = 1; fill_line = 9'd0; fill_tag = 20'h00100;
        @(negedge clk);
        fill_line = 9'd2; fill_tag = 20'h00102;
        @(negedge clk);
        fill_valid = 0;
        exp_hit = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_line = 9'(i); req_tag = 20'h00100 + 20'(i);
            if (i > 0) begin
                #1;
                check($sformatf("b2b_resp%0d", i - 1), {resp_valid, resp_hit}, {1'b1, exp_hit[i-1]});
            end
            @(negedge clk);
        end
        req_valid = 0;
        #1;
        check("b2b_resp3", {resp_valid, resp_hit}, {1'b1, exp_hit[3]});

        @(negedge clk);
        fill_valid = 1; fill_line = 9'd7; fill_tag = 20'h00777;
        @(negedge clk);
        fill_valid = 0; flush_req = 1; req_valid = 1; req_line = 9'd7; req_tag = 20'h00777;
        #1;
        check("flush_cycle_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        #1;
        check("flush_cycle_resp", {resp_valid, resp_hit}, 2'b11);
        check("flush_busy_on", {flush_busy, req_ready, fill_ready}, 3'b100);
        n = 0;
        while (flush_done !== 1'b1 && n < 600) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 10) flush_req = 0;
        end
        check("flush_done_seen", flush_done, 1);
        check("flush_length", n, LINES / 2);
        check("flush_end_state", {flush_busy, req_ready}, 2'b01);
        count_valid("flush_valid_left");
        @(negedge clk);
        req_valid = 1; req_line = 9'd7; req_tag = 20'h00777;
        #1;
        check("flush_done_single", flush_done, 0);
        @(negedge clk);
        req_valid = 0;
        #1;
        check("hit_after_flush", {resp_valid, resp_hit}, 2'b10);

        @(negedge clk);
        flush_req = 1;
        @(negedge clk);
        flush_req = 0;
        repeat (100) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midflush_rst_out", {flush_busy, req_ready, fill_ready, flush_done, resp_valid, resp_hit}, 6'b100000);
        @(negedge clk);
        rst = 1'b0;
        init_flush_check("reinit");

        @(negedge clk);
        req_valid = 1; req_line = 9'd3; req_tag = 20'h0;
        @(posedge clk);
        #1;
        check("pending_resp", resp_valid, 1);
        req_valid = 0;
        @(negedge clk);
        req_valid = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_drops_resp", resp_valid, 0);
        @(negedge clk);
        req_valid = 0; rst = 1'b0;
        init_flush_check("reinit2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
